// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide cache/RAM memory controller:
// IO region code, bus owner encoding, RAM address width and a saturating increment.
package mem_ctrl_pkg;

    localparam int          RAM_ADDR_W = 32;
    localparam logic [1:0]  IO_REGION  = 2'b11;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IC   = 2'd1,
        OWNER_DC   = 2'd2
    } owner_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/mem_ctrl_perf.sv
// Saturating 32-bit performance counter bank for mem_ctrl.
// Only instantiated when MEM_CTRL_PERF_CNT_EN is defined.
module mem_ctrl_perf
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_grant,
    input  logic        dc_grant,
    input  logic        conflict,
    input  logic        io_block,
    output logic [31:0] perf_ic_bytes,
    output logic [31:0] perf_dc_bytes,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_io_block
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ic_bytes <= '0;
            perf_dc_bytes <= '0;
            perf_conflict <= '0;
            perf_io_block <= '0;
        end else begin
            perf_ic_bytes <= sat_inc(perf_ic_bytes, ic_grant);
            perf_dc_bytes <= sat_inc(perf_dc_bytes, dc_grant);
            perf_conflict <= sat_inc(perf_conflict, conflict);
            perf_io_block <= sat_inc(perf_io_block, io_block);
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide arbiter between icache and dcache onto the single-port RAM/IO bus.
// Optional perf counters are enabled with the MEM_CTRL_PERF_CNT_EN macro.
//
//  last_owner | meaning
//  -----------+-------------------------------------------------
//  OWNER_NONE | no grant last cycle, no response this cycle
//  OWNER_IC   | icache granted last cycle, mem_din is its byte
//  OWNER_DC   | dcache granted last cycle, mem_din is its byte/ack
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              io_buffer_full,
    input  logic              ic_get_en,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_out_en,
    output logic [7:0]        ic_content,
    input  logic              dc_get_en,
    input  logic              dc_write_mode,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [7:0]        dc_data,
    output logic              dc_out_en,
    output logic [7:0]        dc_content,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr
`ifdef MEM_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ic_bytes,
    output logic [31:0]       perf_dc_bytes,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_io_block
`endif
);

    owner_t grant;
    owner_t last_owner;
    logic   dc_io_block;

    // IO writes are held off while the IO buffer cannot accept them
    assign dc_io_block = dc_get_en && dc_write_mode && io_buffer_full &&
                         (dc_addr[ADDR_W-1:ADDR_W-2] == IO_REGION);

    // Gating with rst keeps the bus quiet for the whole reset window
    always_comb begin
        grant = OWNER_NONE;
        if (rdy_in && !rst) begin
            if (dc_get_en && !dc_io_block) begin
                grant = OWNER_DC;
            end else if (ic_get_en) begin
                grant = OWNER_IC;
            end
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        case (grant)
            OWNER_DC: begin
                mem_a    = {{(RAM_ADDR_W-ADDR_W){1'b0}}, dc_addr};
                mem_wr   = dc_write_mode;
                mem_dout = dc_data;
            end
            OWNER_IC: begin
                mem_a    = {{(RAM_ADDR_W-ADDR_W){1'b0}}, ic_addr};
                mem_dout = dc_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWNER_NONE;
        end else begin
            last_owner <= grant;
        end
    end

    assign ic_out_en  = (last_owner == OWNER_IC);
    assign dc_out_en  = (last_owner == OWNER_DC);
    assign ic_content = mem_din;
    assign dc_content = mem_din;

`ifdef MEM_CTRL_PERF_CNT_EN
    mem_ctrl_perf u_perf (
        .clk           (clk),
        .rst           (rst),
        .ic_grant      (grant == OWNER_IC),
        .dc_grant      (grant == OWNER_DC),
        .conflict      (ic_get_en && dc_get_en),
        .io_block      (dc_io_block),
        .perf_ic_bytes (perf_ic_bytes),
        .perf_dc_bytes (perf_dc_bytes),
        .perf_conflict (perf_conflict),
        .perf_io_block (perf_io_block)
    );
`endif

endmodule
